// File: rtl/cnt_sched_pkg.sv
// rtl/cnt_sched_pkg.sv - shared types and constants for the counter scheduler
package cnt_sched_pkg;

    localparam int CW_DEF   = 3;
    localparam int NREQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Owner index width; at least one bit even for two requesters.
    function automatic int owner_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnt_sched_if.sv
// rtl/cnt_sched_if.sv - requester / counter bundle seen by the scheduler
interface cnt_sched_if
    import cnt_sched_pkg::*;
#(
    parameter int CW   = CW_DEF,
    parameter int NREQ = NREQ_DEF
);
    localparam int OW = owner_w(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] tgt;
    logic [CW-1:0]      cnt_val;
    logic               cnt_clr;
    logic               cnt_en;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [OW-1:0]      owner;

    modport master (
        output req, tgt, cnt_val,
        input  cnt_clr, cnt_en, gnt, done, busy, owner
    );

    modport slave (
        input  req, tgt, cnt_val,
        output cnt_clr, cnt_en, gnt, done, busy, owner
    );

endinterface

// File: rtl/cnt_sched_rr_arb.sv
// rtl/cnt_sched_rr_arb.sv - combinational round-robin pick starting at ptr
module rr_arb #(
    parameter int NREQ = 4,
    parameter int OW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [OW-1:0]   i_ptr,
    output logic            o_valid,
    output logic [OW-1:0]   o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_valid && i_req[(int'(i_ptr) + k) % NREQ]) begin
                o_valid = 1'b1;
                o_idx   = OW'((int'(i_ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/cnt_sched.sv
// rtl/cnt_sched.sv - round-robin scheduler sharing one up-counter among requesters
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int CW   = CW_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    cnt_sched_if.slave  bus
);

    localparam int OW = owner_w(NREQ);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_tgt_q;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_ptr;
    logic [OW-1:0]   w_win;
    logic [OW-1:0]   w_owner_inc;
    logic            w_valid;
    logic            w_match;
    logic            w_req_own;
    logic [NREQ-1:0] w_own_hot;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] w_done;
    logic            w_cnt_clr;
    logic            w_cnt_en;
    logic            w_busy;

    rr_arb #(.NREQ(NREQ), .OW(OW)) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_win)
    );

    assign w_match     = (bus.cnt_val == r_tgt_q);
    assign w_req_own   = bus.req[r_owner];
    assign w_owner_inc = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_own_hot   = NREQ'(1) << r_owner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Reaching the target wins over a same-cycle request drop.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_valid) w_next = CLR;
            CLR:  w_next = RUN;
            RUN: begin
                if (w_match)         w_next = DONE;
                else if (!w_req_own) w_next = IDLE;
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tgt_q <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            if (r_state == IDLE && w_valid) begin
                r_tgt_q <= bus.tgt[int'(w_win)*CW +: CW];
                r_owner <= w_win;
            end
            if ((r_state == RUN && w_next == IDLE) || r_state == DONE) begin
                r_ptr <= w_owner_inc;
            end
        end
    end

    always_comb begin
        w_gnt     = '0;
        w_done    = '0;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        w_busy    = (r_state != IDLE);
        unique case (r_state)
            CLR: begin
                w_cnt_clr = 1'b1;
                w_gnt     = w_own_hot;
            end
            RUN: begin
                w_gnt    = w_own_hot;
                w_cnt_en = !w_match && w_req_own;
            end
            DONE:    w_done = w_own_hot;
            default: ;
        endcase
    end

    assign bus.gnt     = w_gnt;
    assign bus.done    = w_done;
    assign bus.cnt_clr = w_cnt_clr;
    assign bus.cnt_en  = w_cnt_en;
    assign bus.busy    = w_busy;
    assign bus.owner   = r_owner;

endmodule
